img_stream_loader: RTL

//   Front end of minimobilenet. Accepts a pixel stream (valid/ready, raster order) and assembles

---
 rtl/mmnet_pkg.sv | 14 +
 rtl/frame_bank.sv | 31 +++
 rtl/img_stream_loader.sv | 96 +++++++++
 3 files changed

// File: rtl/mmnet_pkg.sv
// Shared minimobilenet image types and sizing defaults.
// Combinational helpers only; no latency, no flow control.
package mmnet_pkg;
  localparam int DEF_INPUT_SIZE     = 32;
  localparam int DEF_INPUT_CHANNELS = 1;
  localparam int DEF_PX_SIZE        = 8;

  typedef logic [DEF_PX_SIZE-1:0] px_t;
  typedef px_t [DEF_INPUT_SIZE-1:0][DEF_INPUT_SIZE-1:0][DEF_INPUT_CHANNELS-1:0] frame_t;

  function automatic int frame_samples(input int is, input int ic);
    return is * is * ic;
  endfunction
endpackage

// File: rtl/frame_bank.sv
// One full-frame register with a single-sample write port and synchronous clear.
// Write lands 1 cycle after wr_en; the frame output is a plain register, so there is no backpressure.
module frame_bank
  import mmnet_pkg::*;
#(
  parameter int IS = DEF_INPUT_SIZE,
  parameter int IC = DEF_INPUT_CHANNELS,
  parameter int PX = DEF_PX_SIZE,
  localparam int N  = frame_samples(IS, IC),
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [IW-1:0]                        wr_idx,
  input  logic [PX-1:0]                        wr_data,
  output logic [IS-1:0][IS-1:0][IC-1:0][PX-1:0] frame
);
  // Flat sample index k maps to [r][c][ch] because the packed layout has channel fastest.
  logic [N*PX-1:0] mem;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[int'(wr_idx)*PX +: PX] <= wr_data;
    end
  end

  assign frame = mem;
endmodule

// File: rtl/img_stream_loader.sv
// Ping-pong frame loader: raster pixel stream in, settled whole frame out on img_out.
// img_valid follows the last beat by 1+SETTLE_CYCLES; s_ready drops while the write bank is full.
module img_stream_loader
  import mmnet_pkg::*;
#(
  parameter int INPUT_SIZE     = DEF_INPUT_SIZE,
  parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter int PX_SIZE        = DEF_PX_SIZE,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PX_SIZE-1:0]  s_data,
  input  logic                s_last,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_out,
  output logic                img_valid,
  input  logic                img_ack,
  output logic                frame_err
);
  localparam int N  = frame_samples(INPUT_SIZE, INPUT_CHANNELS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  logic [CW-1:0] wcnt;
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank, rd_bank_nxt;
  logic [SW-1:0] settle, settle_nxt;
  logic          accept, last_beat, commit, ack_fire;

  logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame0, frame1;

  assign s_ready   = !rst && !full[wr_bank];
  assign accept    = s_valid && s_ready;
  assign last_beat = (wcnt == CW'(N - 1));
  assign commit    = accept && last_beat;
  assign img_valid = full[rd_bank] && (settle == '0);
  assign ack_fire  = img_ack && img_valid;

  always_comb begin
    full_nxt    = full;
    rd_bank_nxt = rd_bank ^ ack_fire;
    settle_nxt  = settle;
    if (commit)   full_nxt[wr_bank] = 1'b1;
    if (ack_fire) full_nxt[rd_bank] = 1'b0;
    // Restart the timer whenever a frame newly appears on the read side.
    if (full_nxt[rd_bank_nxt] && (!full[rd_bank] || ack_fire)) begin
      settle_nxt = SW'(SETTLE_CYCLES);
    end else if (settle != '0) begin
      settle_nxt = settle - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wcnt      <= '0;
      settle    <= '0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_nxt;
      rd_bank   <= rd_bank_nxt;
      settle    <= settle_nxt;
      frame_err <= accept && (s_last != last_beat);
      if (accept) begin
        // An early s_last abandons the partial frame; the bank is simply refilled from 0.
        if (last_beat || s_last) wcnt <= '0;
        else                     wcnt <= wcnt + CW'(1);
      end
      if (commit) wr_bank <= ~wr_bank;
    end
  end

  frame_bank #(.IS(INPUT_SIZE), .IC(INPUT_CHANNELS), .PX(PX_SIZE)) u_bank0 (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (accept && !wr_bank),
    .wr_idx  (wcnt),
    .wr_data (s_data),
    .frame   (frame0)
  );

  frame_bank #(.IS(INPUT_SIZE), .IC(INPUT_CHANNELS), .PX(PX_SIZE)) u_bank1 (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (accept && wr_bank),
    .wr_idx  (wcnt),
    .wr_data (s_data),
    .frame   (frame1)
  );

  assign img_out = rd_bank ? frame1 : frame0;
endmodule
